// File: rtl/spi_master_tx32.sv
// Mode-0 SPI master: pops one 32-bit word per chip-select frame from the TX FIFO,
// shifts it out MSB-first and returns the 32 captured MISO bits with a 1-cycle strobe.
module spi_master_tx32 #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_fifo_empty,
   output logic        o_fifo_rd_en,
   input  logic [31:0] i_fifo_dout,
   input  logic        i_rx_full,
   output logic [31:0] o_rx_data,
   output logic        o_rx_valid,
   output logic        o_busy,
   output logic        o_spi_sclk,
   output logic        o_spi_cs_n,
   output logic        o_spi_mosi,
   input  logic        i_spi_miso
);

   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? ((CLK_DIV > 2) ? CLK_DIV : 2)
                                               : ((CS_GAP > 2) ? CS_GAP : 2);
   localparam int CW = $clog2(CNT_MAX);
   localparam logic [CW-1:0] DIV_TC = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_TC = CW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_LOAD, S_SHIFT, S_DONE, S_GAP
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [31:0]   r_tx_sr;
   logic [31:0]   r_rx_sr;
   logic [31:0]   r_rx_data;
   logic [4:0]    r_bit_cnt;
   logic [CW-1:0] r_div_cnt;
   logic [CW-1:0] r_gap_cnt;
   logic          r_sclk;
   logic          r_cs_n;
   logic          r_rd_en;
   logic          r_rx_valid;
   logic          r_busy;
   logic          w_tick;
   logic          w_last_fall;

   assign w_tick      = (r_div_cnt == DIV_TC);
   assign w_last_fall = w_tick && r_sclk && (r_bit_cnt == 5'd31);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!i_fifo_empty && !i_rx_full) w_next = S_POP;
         S_POP:   w_next = S_LOAD;
         S_LOAD:  w_next = S_SHIFT;
         S_SHIFT: if (w_last_fall) w_next = S_DONE;
         S_DONE:  w_next = (CS_GAP > 0) ? S_GAP : S_IDLE;
         S_GAP:   if (r_gap_cnt == GAP_TC) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Strobes and busy are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_sr    <= '0;
         r_rx_sr    <= '0;
         r_rx_data  <= '0;
         r_bit_cnt  <= '0;
         r_div_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_sclk     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_rd_en    <= 1'b0;
         r_rx_valid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_rd_en    <= (w_next == S_POP);
         r_rx_valid <= (w_next == S_DONE);
         r_busy     <= (w_next != S_IDLE);
         if (w_next == S_DONE && r_state == S_SHIFT) r_rx_data <= r_rx_sr;
         case (r_state)
            S_LOAD: begin
               r_tx_sr   <= i_fifo_dout;
               r_rx_sr   <= '0;
               r_bit_cnt <= '0;
               r_div_cnt <= '0;
               r_sclk    <= 1'b0;
               r_cs_n    <= 1'b0;
            end
            S_SHIFT: begin
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_sclk    <= ~r_sclk;
                  if (!r_sclk) begin
                     r_rx_sr <= {r_rx_sr[30:0], i_spi_miso};
                  end else if (r_bit_cnt != 5'd31) begin
                     r_tx_sr   <= {r_tx_sr[30:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_cs_n    <= 1'b1;
               r_tx_sr   <= '0;
               r_gap_cnt <= '0;
            end
            S_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // MOSI comes straight off the shift-register MSB, so it is valid from the first SHIFT cycle.
   assign o_spi_mosi   = r_tx_sr[31];
   assign o_spi_sclk   = r_sclk;
   assign o_spi_cs_n   = r_cs_n;
   assign o_fifo_rd_en = r_rd_en;
   assign o_rx_valid   = r_rx_valid;
   assign o_rx_data    = r_rx_data;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_spi_master_tx32.sv
// Directed bench for spi_master_tx32: instance 0 (CLK_DIV=4, CS_GAP=2, MISO looped to MOSI)
// and instance 1 (CLK_DIV=1, CS_GAP=0, MISO tied high), each fed by a small FIFO model.
module tb_spi_master_tx32;

   logic        clk, reset;
   logic [1:0]  empty, rd_en, rx_full, rx_valid, busy, sclk, cs_n, mosi, miso;
   logic [31:0] dout [2];
   logic [31:0] rx_data [2];

   logic [31:0] mem [2][16];
   int          wp [2];
   int          rp [2];

   int n_chk = 0, n_fail = 0;

   int rd_cnt[2], rise_cnt[2], vld_cnt[2], frames[2], starts[2];
   int low_len[2], high_len[2], since_rise[2], last_rise_gap[2], since_vld[2], vld_to_rd[2];
   int sclk_bad[2], dbl_vld[2];
   int low_log[2][8], high_log[2][8];
   logic [31:0] mosi_w[2], mosi_log[2][8], rx_log[2][8];
   logic [1:0]  p_sclk, p_cs, p_vld;

   assign miso  = {1'b1, mosi[0]};
   assign empty = {wp[1] == rp[1], wp[0] == rp[0]};

   spi_master_tx32 #(.CLK_DIV(4), .CS_GAP(2)) u_dut0 (
      .clk(clk), .reset(reset), .i_fifo_empty(empty[0]), .o_fifo_rd_en(rd_en[0]),
      .i_fifo_dout(dout[0]), .i_rx_full(rx_full[0]), .o_rx_data(rx_data[0]),
      .o_rx_valid(rx_valid[0]), .o_busy(busy[0]), .o_spi_sclk(sclk[0]),
      .o_spi_cs_n(cs_n[0]), .o_spi_mosi(mosi[0]), .i_spi_miso(miso[0]));

   spi_master_tx32 #(.CLK_DIV(1), .CS_GAP(0)) u_dut1 (
      .clk(clk), .reset(reset), .i_fifo_empty(empty[1]), .o_fifo_rd_en(rd_en[1]),
      .i_fifo_dout(dout[1]), .i_rx_full(rx_full[1]), .o_rx_data(rx_data[1]),
      .o_rx_valid(rx_valid[1]), .o_busy(busy[1]), .o_spi_sclk(sclk[1]),
      .o_spi_cs_n(cs_n[1]), .o_spi_mosi(mosi[1]), .i_spi_miso(miso[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: registered read data, emptied by the shared reset.
   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            rp[i]   <= wp[i];
            dout[i] <= '0;
         end else if (rd_en[i] && rp[i] != wp[i]) begin
            dout[i] <= mem[i][rp[i] % 16];
            rp[i]   <= rp[i] + 1;
         end
      end
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rd_cnt[i] = 0; rise_cnt[i] = 0; vld_cnt[i] = 0; frames[i] = 0; starts[i] = 0;
         low_len[i] = 0; high_len[i] = 0; since_rise[i] = 0; last_rise_gap[i] = 0;
         since_vld[i] = 0; vld_to_rd[i] = 0; sclk_bad[i] = 0; dbl_vld[i] = 0; mosi_w[i] = '0;
      end
      p_sclk = '0; p_cs = '1; p_vld = '0;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         since_rise[i]++;
         since_vld[i]++;
         if (rd_en[i]) begin
            rd_cnt[i]++;
            vld_to_rd[i] = since_vld[i];
         end
         if (sclk[i] && !p_sclk[i]) begin
            rise_cnt[i]++;
            mosi_w[i] = {mosi_w[i][30:0], mosi[i]};
            last_rise_gap[i] = since_rise[i];
            since_rise[i] = 0;
         end
         if (sclk[i] && cs_n[i]) sclk_bad[i]++;
         if (!cs_n[i]) low_len[i]++;
         if (cs_n[i]) high_len[i]++;
         if (cs_n[i] && !p_cs[i]) begin
            low_log[i][frames[i] % 8]  = low_len[i];
            mosi_log[i][frames[i] % 8] = mosi_w[i];
            frames[i]++;
            low_len[i] = 0;
         end
         if (!cs_n[i] && p_cs[i]) begin
            high_log[i][starts[i] % 8] = high_len[i];
            starts[i]++;
            high_len[i] = 0;
         end
         if (rx_valid[i]) begin
            if (p_vld[i]) dbl_vld[i]++;
            rx_log[i][vld_cnt[i] % 8] = rx_data[i];
            vld_cnt[i]++;
            since_vld[i] = 0;
         end
      end
      p_sclk = sclk; p_cs = cs_n; p_vld = rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input int i, input logic [31:0] w);
      mem[i][wp[i] % 16] = w;
      wp[i] = wp[i] + 1;
   endtask

   task automatic wait_vld(input int i, input int target, input int budget);
      for (int c = 0; c < budget && vld_cnt[i] < target; c++) @(negedge clk);
      chk("wait_rx_valid", vld_cnt[i], target);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_rise(input int i, input int target, input int budget);
      for (int c = 0; c < budget && rise_cnt[i] < target; c++) @(negedge clk);
      chk("wait_sclk_rise", rise_cnt[i], target);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk(tag, {26'd0, cs_n[0], sclk[0], mosi[0], rd_en[0], rx_valid[0], busy[0]},
          32'h0000_0020);
   endtask

   int b_rd, b_rise, b_vld, b_fr, b_st;

   initial begin
      reset = 1'b1; rx_full = '0; wp[0] = 0; wp[1] = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_outputs");
      chk("reset_rx_data", rx_data[0], 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Single loopback frame
      b_rd = rd_cnt[0]; b_rise = rise_cnt[0]; b_vld = vld_cnt[0]; b_fr = frames[0];
      push(0, 32'hA5A5_0F0F);
      wait_vld(0, b_vld + 1, 600);
      chk("t2_rd_pulses", rd_cnt[0] - b_rd, 1);
      chk("t2_sclk_rises", rise_cnt[0] - b_rise, 32);
      chk("t2_mosi_word", mosi_log[0][b_fr % 8], 32'hA5A5_0F0F);
      chk("t2_cs_low_len", low_log[0][b_fr % 8], 257);
      chk("t2_rx_data", rx_log[0][b_vld % 8], 32'hA5A5_0F0F);
      chk("t2_rise_period", last_rise_gap[0], 8);

      // Three back-to-back frames
      b_rd = rd_cnt[0]; b_vld = vld_cnt[0]; b_fr = frames[0]; b_st = starts[0];
      push(0, 32'h0000_0001); push(0, 32'h8000_0000); push(0, 32'hDEAD_BEEF);
      wait_vld(0, b_vld + 3, 1200);
      chk("t3_rd_pulses", rd_cnt[0] - b_rd, 3);
      chk("t3_rx0", rx_log[0][b_vld % 8], 32'h0000_0001);
      chk("t3_rx1", rx_log[0][(b_vld + 1) % 8], 32'h8000_0000);
      chk("t3_rx2", rx_log[0][(b_vld + 2) % 8], 32'hDEAD_BEEF);
      chk("t3_mosi2", mosi_log[0][(b_fr + 2) % 8], 32'hDEAD_BEEF);
      chk("t3_cs_gap1", high_log[0][(b_st + 1) % 8], 5);
      chk("t3_cs_gap2", high_log[0][(b_st + 2) % 8], 5);
      chk("t3_done_to_pop", vld_to_rd[0], 4);
      repeat (5) @(negedge clk);
      chk("t3_idle_busy", busy[0], 1'b0);

      // Asynchronous reset at a random point of a frame
      b_vld = vld_cnt[0];
      push(0, 32'h5555_AAAA);
      repeat ($urandom_range(8, 250)) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_outputs("t1_reset_midframe");
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("t1_no_rx_valid", vld_cnt[0] - b_vld, 0);

      // rx_full holds off new frames but never aborts one
      b_rd = rd_cnt[0]; b_vld = vld_cnt[0]; b_rise = rise_cnt[0];
      rx_full[0] = 1'b1;
      push(0, 32'h3C3C_C3C3);
      repeat (100) @(negedge clk);
      chk("t4_blocked_rd", rd_cnt[0] - b_rd, 0);
      chk("t4_blocked_busy", busy[0], 1'b0);
      rx_full[0] = 1'b0;
      wait_rise(0, b_rise + 6, 200);
      rx_full[0] = 1'b1;
      wait_vld(0, b_vld + 1, 600);
      chk("t4_rx_data", rx_log[0][b_vld % 8], 32'h3C3C_C3C3);
      chk("t4_rd_pulses", rd_cnt[0] - b_rd, 1);
      rx_full[0] = 1'b0;

      // Reset at bit 10, then a clean frame
      b_vld = vld_cnt[0]; b_rise = rise_cnt[0];
      push(0, 32'h1234_5678);
      wait_rise(0, b_rise + 11, 300);
      #2 reset = 1'b1;
      #1 check_reset_outputs("t5_reset_bit10");
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("t5_no_rx_valid", vld_cnt[0] - b_vld, 0);
      b_fr = frames[0];
      push(0, 32'hCAFE_F00D);
      wait_vld(0, b_vld + 1, 600);
      chk("t5_rx_data", rx_log[0][b_vld % 8], 32'hCAFE_F00D);
      chk("t5_mosi_word", mosi_log[0][b_fr % 8], 32'hCAFE_F00D);

      // Fastest divider, no gap, MISO tied high
      b_rd = rd_cnt[1]; b_vld = vld_cnt[1]; b_fr = frames[1];
      push(1, 32'h0000_0000); push(1, 32'h0F0F_1234);
      wait_vld(1, b_vld + 2, 400);
      chk("t6_rd_pulses", rd_cnt[1] - b_rd, 2);
      chk("t6_rx0", rx_log[1][b_vld % 8], 32'hFFFF_FFFF);
      chk("t6_rx1", rx_log[1][(b_vld + 1) % 8], 32'hFFFF_FFFF);
      chk("t6_cs_low_len", low_log[1][b_fr % 8], 65);
      chk("t6_mosi_word", mosi_log[1][(b_fr + 1) % 8], 32'h0F0F_1234);
      chk("t6_rise_period", last_rise_gap[1], 2);
      chk("t6_done_to_pop", vld_to_rd[1], 2);
      chk("t6_idle_busy", busy[1], 1'b0);

      chk("sclk_while_cs_high", sclk_bad[0] + sclk_bad[1], 0);
      chk("rx_valid_width", dbl_vld[0] + dbl_vld[1], 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
